// File: rtl/shift_result_stage.sv
// Registered result stage behind the barrel left-shifter: derives Z/N/C (and optional V)
// flags on push and buffers entries in a 2-deep FIFO. Optional V flag: SHIFT_RESULT_OVF_EN.
module shift_result_stage #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [SHW-1:0]   in_sel,
  input  logic [WIDTH-1:0] in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
`ifdef SHIFT_RESULT_OVF_EN
  output logic             out_v,
`endif
  output logic [1:0]       out_count
);

  // Handshake: a transfer happens on a side only in a cycle where both valid and ready
  // are high; in_ready depends on occupancy alone, never on out_ready.
`ifdef SHIFT_RESULT_OVF_EN
  localparam int FW = 4;
`else
  localparam int FW = 3;
`endif
  localparam int EW = WIDTH + FW;

  logic [1:0]    count;
  logic [EW-1:0] head_q;
  logic [EW-1:0] tail_q;
  logic [EW-1:0] new_entry;
  logic          push;
  logic          pop;
  logic [SHW-1:0] c_idx;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Two's-complement negate of sel gives WIDTH-sel for every non-zero shift amount.
  assign c_idx  = '0 - in_sel;
  assign flag_z = (in_result == '0);
  assign flag_n = in_result[WIDTH-1];
  assign flag_c = (in_sel != '0) ? in_operand[c_idx] : 1'b0;

`ifdef SHIFT_RESULT_OVF_EN
  logic flag_v;

  // Overflow when any of the top sel+1 operand bits differs from the sign bit.
  always_comb begin
    flag_v = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i + int'(in_sel) >= WIDTH - 1) && (in_operand[i] != in_operand[WIDTH-1])) begin
        flag_v = 1'b1;
      end
    end
  end

  assign new_entry = {in_result, flag_z, flag_n, flag_c, flag_v};
  assign out_v     = head_q[0];
`else
  assign new_entry = {in_result, flag_z, flag_n, flag_c};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_q <= new_entry;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= new_entry;
          end else if (push) begin
            tail_q <= new_entry;
            count  <= 2'd2;
          end else if (pop) begin
            // Head keeps the popped values on the way to empty.
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            count  <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign out_result = head_q[EW-1 -: WIDTH];
  assign out_z      = head_q[FW-1];
  assign out_n      = head_q[FW-2];
  assign out_c      = head_q[FW-3];
  assign out_count  = count;

endmodule

// File: tb/tb_shift_result_stage.sv
// Bench for shift_result_stage: directed flag/boundary vectors plus random traffic,
// scoreboarded against a flag model computed with plain arithmetic.
module tb_shift_result_stage;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int EW    = WIDTH + 4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_operand;
  logic [SHW-1:0]   in_sel;
  logic [WIDTH-1:0] in_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_z;
  logic             out_n;
  logic             out_c;
  logic             v_act;
  logic [1:0]       out_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  shift_result_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_operand (in_operand),
    .in_sel     (in_sel),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_z      (out_z),
    .out_n      (out_n),
    .out_c      (out_c),
`ifdef SHIFT_RESULT_OVF_EN
    .out_v      (v_act),
`endif
    .out_count  (out_count)
  );

`ifndef SHIFT_RESULT_OVF_EN
  assign v_act = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [31:0] op, input logic [4:0] sel,
                                          input logic [31:0] res);
    logic z, n, c, v;
    z = (res == 32'd0);
    n = res[31];
    c = 1'b0;
    if (sel != 5'd0) c = ((op >> (32 - int'(sel))) & 32'd1) != 32'd0;
    v = 1'b0;
`ifdef SHIFT_RESULT_OVF_EN
    if (sel != 5'd0) begin
      logic signed [31:0] sh;
      sh = op << sel;
      v = ((sh >>> sel) != $signed(op));
    end
`endif
    return {res, z, n, c, v};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Input side: record what the next rising edge will accept.
  always @(negedge clk) begin
    #1;
    if (reset || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(in_operand, in_sel, in_result));
  end

  // Output side monitor.
  always @(negedge clk) begin
    if (!reset) begin
      check("count", 64'(out_count), 64'(exp_q.size()));
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) check("underflow", 64'd1, 64'd0);
        else check("head", 64'({out_result, out_z, out_n, out_c, v_act}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [31:0] op, input logic [4:0] sel, input logic [31:0] res);
    in_operand = op;
    in_sel     = sel;
    in_result  = res;
    in_valid   = 1'b1;
  endtask

  task automatic push_wait(input logic [31:0] op, input logic [4:0] sel, input logic [31:0] res);
    logic acc;
    logic done;
    set_in(op, sel, res);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      done = acc;
    end
    if (!done) check("push_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  logic [31:0] vo [5] = '{32'hFFFFFE01, 32'hFC8EC295, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
  logic [4:0]  vs [5] = '{5'd0, 5'd1, 5'd1, 5'd31, 5'd31};
  logic [31:0] vr [5] = '{32'hFFFFFE01, 32'hF91D852A, 32'h00000000, 32'h80000000, 32'h80000000};
  logic [3:0]  vf [5] = '{4'b0100, 4'b0110, 4'b1011, 4'b0101, 4'b0110};

  // ---------------- stimulus ----------------
  initial begin
    logic stall;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_operand = '0; in_sel = '0; in_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'({out_result, out_z, out_n, out_c, v_act}), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Directed flag vectors, one at a time with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_wait(vo[i], vs[i], vr[i]);
      @(negedge clk);
      check("dir_valid", 64'(out_valid), 64'd1);
      check("dir_count", 64'(out_count), 64'd1);
      check("dir_result", 64'(out_result), 64'(vr[i]));
      check("dir_zn_c", 64'({out_z, out_n, out_c}), 64'(vf[i][3:1]));
`ifdef SHIFT_RESULT_OVF_EN
      check("dir_v", 64'(v_act), 64'(vf[i][0]));
`endif
      @(posedge clk);
      #1;
    end
    // Popped to empty: head keeps last values.
    @(negedge clk);
    check("empty_valid", 64'(out_valid), 64'd0);
    check("empty_hold", 64'({out_result, out_z, out_n, out_c}), 64'({32'h80000000, 3'b011}));
    @(posedge clk);
    #1;

    // Back-pressure: A, B fill, C stalls until A pops.
    out_ready = 1'b0;
    push_wait(32'h11111111, 5'd4, 32'h11111110);
    push_wait(32'h22222222, 5'd8, 32'h22222200);
    set_in(32'h33333333, 5'd2, 32'hCCCCCCCC);
    @(negedge clk);
    check("bp_ready", 64'(in_ready), 64'd0);
    check("bp_count", 64'(out_count), 64'd2);
    check("bp_head", 64'(out_result), 64'h11111110);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_wait(32'h33333333, 5'd2, 32'hCCCCCCCC);
    @(negedge clk);
    check("bp_c_head", 64'(out_result), 64'hCCCCCCCC);
    @(posedge clk);
    #1;

    // Flush at full with a push pending.
    out_ready = 1'b0;
    push_wait(32'h0000F00D, 5'd3, 32'h00078068);
    push_wait(32'hDEADBEEF, 5'd1, 32'hBD5B7DDE);
    set_in(32'h12345678, 5'd0, 32'h12345678);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl_count", 64'(out_count), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_data", 64'({out_result, out_z, out_n, out_c, v_act}), 64'd0);

    // Flush at count 1 with simultaneous push and pop.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_wait(32'h0F0F0F0F, 5'd4, 32'hF0F0F0F0);
    set_in(32'h00000003, 5'd30, 32'hC0000000);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl2_count", 64'(out_count), 64'd0);
    check("fl2_data", 64'(out_result), 64'd0);

    // Asynchronous reset in the middle of a cycle with two entries held.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push_wait(32'hAAAA5555, 5'd7, 32'h552AAA80);
    push_wait(32'h5555AAAA, 5'd9, 32'hAB555400);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(out_count), 64'd0);
    check("arst_data", 64'({out_result, out_z, out_n, out_c, v_act}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    push_wait(32'h00000001, 5'd31, 32'h80000000);

    // Random traffic; inputs held while stalled.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      stall = in_valid && !in_ready;
      @(posedge clk);
      #1;
      if (!stall) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       in_operand = 32'h0;
          1:       in_operand = 32'hFFFFFFFF;
          default: in_operand = $urandom;
        endcase
        in_sel    = 5'($urandom_range(0, 31));
        in_result = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (in_operand << in_sel);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_q", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(out_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
